// File: rtl/mul_issue_ctrl_if.sv
// Issue, writeback and multiplier-side signals of the multiply issue controller.
// slave = controller view; master = the surrounding pipeline/multiplier view.
interface mul_issue_ctrl_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic        in_word;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;
  logic        m_valid;
  logic [1:0]  m_signed;
  logic        m_word;
  logic [63:0] m_op1;
  logic [63:0] m_op2;
  logic        m_flush;
  logic        m_ready;
  logic        m_out_valid;
  logic [63:0] m_hi;
  logic [63:0] m_lo;

  modport slave (
    input  flush, in_valid, in_op, in_word, in_src1, in_src2, in_rd,
    input  out_ready, m_ready, m_out_valid, m_hi, m_lo,
    output in_ready, out_valid, out_result, out_rd, busy,
    output m_valid, m_signed, m_word, m_op1, m_op2, m_flush
  );

  modport master (
    output flush, in_valid, in_op, in_word, in_src1, in_src2, in_rd,
    output out_ready, m_ready, m_out_valid, m_hi, m_lo,
    input  in_ready, out_valid, out_result, out_rd, busy,
    input  m_valid, m_signed, m_word, m_op1, m_op2, m_flush
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// RV64M multiply issue controller: launches the Booth core, selects the result, zero/repeat shortcuts.
// Hit/zero: result 1 cycle after accept; miss: 1 cycle after product. Result held in HOLD until out_ready.
module mul_issue_ctrl (
  input  logic            clk,
  input  logic            rst,
  mul_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic        word_q;
  logic [63:0] src1_q;
  logic [63:0] src2_q;
  logic [4:0]  rd_q;
  logic [1:0]  sgn_q;
  logic [63:0] res_q;

  logic        c_vld;
  logic [63:0] c_src1;
  logic [63:0] c_src2;
  logic [1:0]  c_sgn;
  logic        c_word;
  logic [63:0] c_hi;
  logic [63:0] c_lo;

  logic        accept;
  logic [1:0]  in_sgn;
  logic        in_zero;
  logic        hit;

  function automatic logic [63:0] sel_result(input logic [1:0]  op,
                                             input logic        word,
                                             input logic [63:0] hi,
                                             input logic [63:0] lo);
    if (word)
      return {{32{lo[31]}}, lo[31:0]};
    else if (op == 2'b00)
      return lo;
    else
      return hi;
  endfunction

  assign accept  = (state == IDLE) && bus.in_valid && bus.in_ready;
  // MUL, MULH and MULW are fully signed; MULHSU signs op1 only; MULHU is unsigned.
  assign in_sgn  = (bus.in_word || !bus.in_op[1]) ? 2'b11 : (bus.in_op[0] ? 2'b00 : 2'b01);
  assign in_zero = bus.in_word ? ((bus.in_src1[31:0] == 32'd0) || (bus.in_src2[31:0] == 32'd0))
                               : ((bus.in_src1 == 64'd0) || (bus.in_src2 == 64'd0));
  assign hit     = c_vld && (c_src1 == bus.in_src1) && (c_src2 == bus.in_src2) &&
                   (c_sgn == in_sgn) && (c_word == bus.in_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      word_q <= 1'b0;
      src1_q <= 64'd0;
      src2_q <= 64'd0;
      rd_q   <= 5'd0;
      sgn_q  <= 2'b00;
      res_q  <= 64'd0;
      c_vld  <= 1'b0;
      c_src1 <= 64'd0;
      c_src2 <= 64'd0;
      c_sgn  <= 2'b00;
      c_word <= 1'b0;
      c_hi   <= 64'd0;
      c_lo   <= 64'd0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= bus.in_op;
            word_q <= bus.in_word;
            src1_q <= bus.in_src1;
            src2_q <= bus.in_src2;
            rd_q   <= bus.in_rd;
            sgn_q  <= in_sgn;
            if (in_zero) begin
              res_q <= 64'd0;
              state <= HOLD;
            end else if (hit) begin
              res_q <= sel_result(bus.in_op, bus.in_word, c_hi, c_lo);
              state <= HOLD;
            end else begin
              state <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (bus.m_ready)
            state <= WAIT;
        end
        WAIT: begin
          if (bus.m_out_valid) begin
            res_q  <= sel_result(op_q, word_q, bus.m_hi, bus.m_lo);
            c_vld  <= 1'b1;
            c_src1 <= src1_q;
            c_src2 <= src2_q;
            c_sgn  <= sgn_q;
            c_word <= word_q;
            c_hi   <= bus.m_hi;
            c_lo   <= bus.m_lo;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flush gates the handshakes combinationally so a killed op never completes.
  assign bus.in_ready   = !rst && (state == IDLE) && !bus.flush;
  assign bus.out_valid  = !rst && (state == HOLD) && !bus.flush;
  assign bus.out_result = bus.out_valid ? res_q : 64'd0;
  assign bus.out_rd     = bus.out_valid ? rd_q : 5'd0;
  assign bus.busy       = !rst && (state != IDLE);
  assign bus.m_valid    = !rst && (state == LAUNCH) && bus.m_ready && !bus.flush;
  assign bus.m_flush    = !rst && bus.flush && ((state == LAUNCH) || (state == WAIT));
  assign bus.m_signed   = sgn_q;
  assign bus.m_word     = word_q;
  assign bus.m_op1      = src1_q;
  assign bus.m_op2      = src2_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural multiplier of programmable latency.
module tb_mul_issue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_issue_ctrl_if ifc();

  mul_issue_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_mvalid = 0;
  int mlat = 2;
  logic [68:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) if (ifc.m_valid) n_mvalid++;

  // Multiplier model: full 128-bit product with the requested signedness.
  initial begin
    logic [127:0] x1, x2, p;
    ifc.m_out_valid = 1'b0;
    ifc.m_hi = 64'd0;
    ifc.m_lo = 64'd0;
    forever begin
      @(negedge clk);
      if (ifc.m_valid) begin
        x1 = ifc.m_signed[0] ? {{64{ifc.m_op1[63]}}, ifc.m_op1} : {64'd0, ifc.m_op1};
        x2 = ifc.m_signed[1] ? {{64{ifc.m_op2[63]}}, ifc.m_op2} : {64'd0, ifc.m_op2};
        p  = x1 * x2;
        repeat (mlat) @(posedge clk);
        #1;
        ifc.m_out_valid = 1'b1;
        ifc.m_hi = p[127:64];
        ifc.m_lo = p[63:0];
        @(posedge clk);
        #1;
        ifc.m_out_valid = 1'b0;
        ifc.m_hi = 64'd0;
        ifc.m_lo = 64'd0;
      end
    end
  end

  // Monitor: pops an expectation on every output handshake.
  initial begin
    logic [68:0] e;
    forever begin
      @(negedge clk);
      if (!rst && ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got rd %0d result %h, expected none", ifc.out_rd, ifc.out_result);
        end else begin
          e = exp_q.pop_front();
          chk("out_result", ifc.out_result, e[63:0]);
          chk("out_rd", {59'd0, ifc.out_rd}, {59'd0, e[68:64]});
        end
      end else if (!ifc.out_valid) begin
        chk("idle_out_zero", {ifc.out_result[63:5], ifc.out_result[4:0] | ifc.out_rd}, 64'd0);
      end
    end
  end

  task automatic wait_idle(input string nm);
    int c = 0;
    while (ifc.busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) chk({nm, "_idle_timeout"}, 64'd1, 64'd0);
  endtask

  // Offers one op, waits for the accept, then checks launch attributes and first-cycle latency.
  task automatic send(input string nm, input logic [1:0] op, input logic word,
                      input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                      input logic [63:0] res, input logic fast, input logic [1:0] sgn,
                      input logic hold);
    int c = 0;
    int l0;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b1;
    ifc.in_op    = op;
    ifc.in_word  = word;
    ifc.in_src1  = a;
    ifc.in_src2  = b;
    ifc.in_rd    = rd;
    @(negedge clk);
    while (!ifc.in_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) chk({nm, "_accept_timeout"}, 64'd1, 64'd0);
    exp_q.push_back({rd, res});
    l0 = n_mvalid;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_m_signed"}, {62'd0, ifc.m_signed}, {62'd0, sgn});
    chk({nm, "_m_word"}, {63'd0, ifc.m_word}, {63'd0, word});
    if (fast) chk({nm, "_out_valid_T+1"}, {63'd0, ifc.out_valid}, 64'd1);
    else      chk({nm, "_m_valid_T+1"}, {63'd0, ifc.m_valid}, {63'd0, ifc.m_ready});
    if (!hold) begin
      wait_idle(nm);
      chk({nm, "_launches"}, 64'(n_mvalid - l0), fast ? 64'd0 : 64'd1);
    end
  endtask

  initial begin
    int l0;
    int c;
    ifc.flush     = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_op     = 2'b00;
    ifc.in_word   = 1'b0;
    ifc.in_src1   = 64'd0;
    ifc.in_src2   = 64'd0;
    ifc.in_rd     = 5'd0;
    ifc.out_ready = 1'b1;
    ifc.m_ready   = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, ifc.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("rst_busy", {63'd0, ifc.busy}, 64'd0);
    chk("rst_m_valid", {63'd0, ifc.m_valid}, 64'd0);
    chk("rst_m_flush", {63'd0, ifc.m_flush}, 64'd0);
    chk("rst_m_op1", ifc.m_op1, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);

    send("mulhu", 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'd1, 1'b0, 2'b00, 1'b0);
    send("mulh", 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'd0, 1'b0, 2'b11, 1'b0);
    send("mul_hit", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'd1, 1'b1, 2'b11, 1'b0);
    send("mulw", 2'b01, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 2'b11, 1'b0);
    send("mul_zero", 2'b00, 1'b0, 64'h1234, 64'd0, 5'd9, 64'd0, 1'b1, 2'b11, 1'b0);
    send("mulw_hit", 2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 2'b11, 1'b0);
    send("mulw_zero", 2'b00, 1'b1, 64'hABCD_0000_0000, 64'd5, 5'd11, 64'd0, 1'b1, 2'b11, 1'b0);

    // Flush three cycles into WAIT with a slow multiplier.
    mlat = 6;
    l0 = n_mvalid;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b1;
    ifc.in_op    = 2'b00;
    ifc.in_word  = 1'b0;
    ifc.in_src1  = 64'd3;
    ifc.in_src2  = 64'd5;
    ifc.in_rd    = 5'd12;
    @(negedge clk);
    chk("flush_accept_ready", {63'd0, ifc.in_ready}, 64'd1);
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_m_valid", {63'd0, ifc.m_valid}, 64'd1);
    repeat (3) @(posedge clk);
    #1 ifc.flush = 1'b1;
    @(negedge clk);
    chk("flush_m_flush", {63'd0, ifc.m_flush}, 64'd1);
    chk("flush_in_ready", {63'd0, ifc.in_ready}, 64'd0);
    @(posedge clk);
    #1 ifc.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_after", {63'd0, ifc.busy}, 64'd0);
    chk("flush_m_flush_after", {63'd0, ifc.m_flush}, 64'd0);
    repeat (8) @(negedge clk);
    chk("flush_launches", 64'(n_mvalid - l0), 64'd1);
    mlat = 2;
    send("mul_after_flush", 2'b00, 1'b0, 64'd3, 64'd5, 5'd13, 64'd15, 1'b0, 2'b11, 1'b0);
    send("mulhsu", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b01, 1'b0);

    // Flush together with in_valid in IDLE: no accept.
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b1;
    ifc.flush    = 1'b1;
    ifc.in_src1  = 64'd9;
    ifc.in_src2  = 64'd9;
    ifc.in_rd    = 5'd20;
    @(negedge clk);
    chk("flush_idle_in_ready", {63'd0, ifc.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.flush    = 1'b0;
    @(negedge clk);
    chk("flush_idle_no_accept", {63'd0, ifc.busy}, 64'd0);

    // Multiplier not ready: controller waits in LAUNCH.
    ifc.m_ready = 1'b0;
    l0 = n_mvalid;
    send("mul_stall", 2'b00, 1'b0, 64'h10, 64'h10, 5'd16, 64'h100, 1'b0, 2'b11, 1'b1);
    @(negedge clk);
    chk("stall_busy", {63'd0, ifc.busy}, 64'd1);
    chk("stall_no_launch", 64'(n_mvalid - l0), 64'd0);
    @(posedge clk);
    #1 ifc.m_ready = 1'b1;
    @(negedge clk);
    chk("stall_m_valid", {63'd0, ifc.m_valid}, 64'd1);
    wait_idle("mul_stall");
    chk("stall_launches", 64'(n_mvalid - l0), 64'd1);

    // Writeback backpressure in HOLD.
    ifc.out_ready = 1'b0;
    send("mul_bp", 2'b00, 1'b0, 64'd7, 64'd6, 5'd15, 64'h2A, 1'b0, 2'b11, 1'b1);
    c = 0;
    while (!ifc.out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) chk("bp_out_valid_timeout", 64'd1, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", {63'd0, ifc.out_valid}, 64'd1);
      chk("bp_out_result", ifc.out_result, 64'h2A);
      chk("bp_out_rd", {59'd0, ifc.out_rd}, 64'd15);
      chk("bp_in_ready", {63'd0, ifc.in_ready}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 ifc.out_ready = 1'b1;
    @(negedge clk);
    wait_idle("mul_bp");
    chk("bp_in_ready_after", {63'd0, ifc.in_ready}, 64'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
